generic_cbus_slave_wr_ctl: RTL and testbench
============================================

// Module: generic_cbus_slave_wr_ctl
// PURPOSE
//  CBUS write responder. Accepts write beats from a CBUS write master
//  (req/address/bytecnt/byten/first/last/wdata, with wready backpressure).
//  Buffers beats in a small FIFO and drains them to an SRAM-style write port.
//  Checks each beat against the burst protocol and reports violations.
//  Sits between the CBUS fabric and a register file or local memory.
// PARAMETERS
//  FIFO_DEPTH  4   beat buffer depth; power of 2, >=2
//  ADDR_W      32  CBUS address width
// PORTS
//  cbus_clk      in   1       clock
//  rst           in   1       async reset, active high
//  big_endian_q  in   1       byten lane order from master (1 = reversed)
//  cbus_req      in   1       beat valid
//  cbus_address  in   ADDR_W  beat address; word aligned
//  cbus_bytecnt  in   10      bytes remaining, including this beat
//  cbus_byten    in   4       byte enables
//  cbus_first    in   1       first beat of burst
//  cbus_last     in   1       last beat of burst
//  cbus_wdata    in   32      beat data
//  cbus_wready   out  1       beat accepted when cbus_req && cbus_wready
//  mem_wr        out  1       memory write request
//  mem_addr      out  ADDR_W  memory word address (byte addr, [1:0]=0)
//  mem_be        out  4       byte enables, always little-endian lane order
//  mem_wdata     out  32      write data
//  mem_gnt       in   1       write completes when mem_wr && mem_gnt
//  burst_done    out  1       1-cycle pulse: last beat of a burst written
//  err           out  1       sticky: any protocol error
//  err_code      out  5       sticky per-class error bits
//  err_clr       in   1       clears err/err_code
// BEHAVIOUR
//  Reset (async): all outputs 0, FIFO empty, state IDLE, expected regs 0.
//  cbus_wready = ~fifo_full. It is driven from registered count only, with no
//   combinational path from cbus_req.
//  A beat accepted in cycle N is visible on mem_* in cycle N+1 at the earliest.
//  mem_wr = ~fifo_empty. mem_addr, mem_be and mem_wdata are held stable until
//   mem_gnt; the FIFO pops on mem_wr && mem_gnt.
//  Push and pop in the same cycle are allowed at any count.
//   When full, push is impossible because wready=0.
//  mem_be = big_endian_q ? bit-reverse(cbus_byten) : cbus_byten.
//   Sampled at push.
//  FSM (checker), advancing only on accepted beats:
//   IDLE:
//    - first=1: start burst.
//      exp_addr = address + 4; exp_cnt = bytecnt - 4.
//      Go to BURST, unless last=1 (then stay IDLE).
//    - first=0: ORDER error; beat dropped, not pushed.
//   BURST:
//    - first=0: check the beat; exp_addr += 4; exp_cnt -= 4.
//      last=1 -> IDLE.
//    - first=1: ORDER error; beat treated as a new burst start.
//  Checks on every pushed beat. Violations set err_code bits:
//   [0] ORDER: see FSM.
//   [1] ADDR: address[1:0] != 0, or (BURST) address != exp_addr.
//   [2] CNT: (BURST) bytecnt != exp_cnt, or bytecnt == 0.
//   [3] BYTEN: mem_be != f(bytecnt), where f(>=4)=1111, f(3)=0111,
//       f(2)=0011, f(1)=0001, f(0)=0000.
//   [4] LAST: last != (bytecnt in 1..4).
//  Erroneous beats other than IDLE/ORDER are still pushed and written.
//  Width rules: exp_cnt is 10-bit, wraps mod 1024.
//   exp_addr is ADDR_W bits, wraps mod 2^ADDR_W.
//  err = |err_code. err_clr clears all bits. A new error in the same cycle
//   as err_clr wins (bit stays set).
//  Each FIFO entry carries a last flag. burst_done pulses the cycle after the
//   pop of an entry with last=1.
//  Reset mid-burst: FIFO contents discarded, FSM to IDLE. A master still
//   mid-burst then produces an ORDER error on its next beat.
// TESTING
//  1. 12-byte burst at 0x100, le, mem_gnt=1:
//     3 beats -> mem writes 0x100/0x104/0x108, be=1111 each,
//     1 burst_done, err=0.
//  2. 6-byte burst at 0x200, big_endian_q=1, master byten 1111 then 1100:
//     -> mem_be 1111 then 0011, no error.
//  3. mem_gnt=0 for 10 cycles with 8 beats offered, FIFO_DEPTH=4:
//     -> wready low after 4 accepts, mem_* stable.
//     After gnt, all 8 written in order, none lost.
//  4. Second beat address 0x108 instead of 0x104:
//     -> err_code=00010, beat still written. err_clr -> err=0.
//  5. Non-first beat while IDLE: -> err_code[0]=1, no mem_wr.
//     first=1 mid-burst -> ORDER set, new burst tracked from the new address.
//  6. Assert rst with 3 beats queued: -> mem_wr=0, wready=1, err=0
//     immediately (async). Next clean burst passes.

Source files
------------

// File: rtl/generic_cbus_slave_wr_ctl_if.sv
// CBUS write channel between a write master and generic_cbus_slave_wr_ctl.
//   cbus_req      beat valid (master -> slave)
//   cbus_address  beat byte address, expected word aligned
//   cbus_bytecnt  bytes remaining in the burst, including this beat
//   cbus_byten    byte enables in the master's lane order
//   cbus_first    first beat of a burst
//   cbus_last     last beat of a burst
//   cbus_wdata    beat data
//   cbus_wready   slave can take a beat (slave -> master)
interface generic_cbus_slave_wr_ctl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cbus_req;
  logic [ADDR_W-1:0] cbus_address;
  logic [9:0]        cbus_bytecnt;
  logic [3:0]        cbus_byten;
  logic              cbus_first;
  logic              cbus_last;
  logic [31:0]       cbus_wdata;
  logic              cbus_wready;

  modport master (
    output cbus_req, cbus_address, cbus_bytecnt, cbus_byten,
           cbus_first, cbus_last, cbus_wdata,
    input  cbus_wready
  );

  modport slave (
    input  cbus_req, cbus_address, cbus_bytecnt, cbus_byten,
           cbus_first, cbus_last, cbus_wdata,
    output cbus_wready
  );
endinterface

// File: rtl/generic_cbus_slave_wr_ctl.sv
// CBUS write responder. Accepts write beats, buffers them in a small FIFO and
// drains them to an SRAM-style write port, while checking each accepted beat
// against the burst protocol and latching sticky error bits.
//   cbus_clk      clock
//   rst           asynchronous reset, active high
//   big_endian_q  1 = master byte-enable lanes are reversed
//   cbus          CBUS write channel (slave side)
//   mem_wr        memory write request (FIFO not empty)
//   mem_addr      word-aligned byte address of the head entry
//   mem_be        byte enables, little-endian lane order
//   mem_wdata     write data
//   mem_gnt       write completes when mem_wr && mem_gnt
//   burst_done    one-cycle pulse after the last beat of a burst is written
//   err           OR of err_code
//   err_code      sticky {LAST, BYTEN, CNT, ADDR, ORDER}
//   err_clr       clears err_code; a same-cycle new error still sets its bit
module generic_cbus_slave_wr_ctl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                      cbus_clk,
  input  logic                      rst,
  input  logic                      big_endian_q,
  generic_cbus_slave_wr_ctl_if.slave cbus,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [3:0]                mem_be,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_gnt,
  output logic                      burst_done,
  output logic                      err,
  output logic [4:0]                err_code,
  input  logic                      err_clr
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // FIFO storage and control
  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [3:0]        be_mem_q   [FIFO_DEPTH];
  logic [31:0]       data_mem_q [FIFO_DEPTH];
  logic              last_mem_q [FIFO_DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          fifo_full;
  logic          accept;
  logic          push;
  logic          pop;

  // Checker state
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [9:0]        exp_cnt_q, exp_cnt_d;
  logic [4:0]        err_code_q, err_code_d;
  logic [4:0]        err_new;
  logic              burst_done_q, burst_done_d;

  logic [3:0] be_in;
  logic [3:0] be_exp;
  logic       last_ok;

  assign fifo_full        = (count_q == (PW+1)'(FIFO_DEPTH));
  assign cbus.cbus_wready = ~fifo_full;
  assign accept           = cbus.cbus_req & ~fifo_full;
  assign mem_wr           = (count_q != '0);
  assign pop              = mem_wr & mem_gnt;

  // Head entry is only meaningful while mem_wr is high; gating keeps the
  // outputs at zero while empty and after reset.
  assign mem_addr   = mem_wr ? addr_mem_q[rptr_q] : '0;
  assign mem_be     = mem_wr ? be_mem_q[rptr_q]   : '0;
  assign mem_wdata  = mem_wr ? data_mem_q[rptr_q] : '0;
  assign burst_done = burst_done_q;
  assign err_code   = err_code_q;
  assign err        = |err_code_q;

  always_comb begin
    be_in = big_endian_q ? {cbus.cbus_byten[0], cbus.cbus_byten[1],
                            cbus.cbus_byten[2], cbus.cbus_byten[3]}
                         : cbus.cbus_byten;
    if (cbus.cbus_bytecnt >= 10'd4) begin
      be_exp = 4'b1111;
    end else begin
      case (cbus.cbus_bytecnt[1:0])
        2'd3:    be_exp = 4'b0111;
        2'd2:    be_exp = 4'b0011;
        2'd1:    be_exp = 4'b0001;
        default: be_exp = 4'b0000;
      endcase
    end
    last_ok = (cbus.cbus_bytecnt != 10'd0) && (cbus.cbus_bytecnt <= 10'd4);
  end

  always_comb begin
    state_d    = state_q;
    exp_addr_d = exp_addr_q;
    exp_cnt_d  = exp_cnt_q;
    err_new    = '0;
    push       = 1'b0;
    if (accept) begin
      if ((state_q == ST_IDLE) && !cbus.cbus_first) begin
        // Stray continuation beat: flagged and dropped.
        err_new[0] = 1'b1;
      end else begin
        push = 1'b1;
        if ((state_q == ST_BURST) && !cbus.cbus_first) begin
          err_new[1] = (cbus.cbus_address[1:0] != 2'b00) ||
                       (cbus.cbus_address != exp_addr_q);
          err_new[2] = (cbus.cbus_bytecnt != exp_cnt_q) ||
                       (cbus.cbus_bytecnt == 10'd0);
          exp_addr_d = exp_addr_q + ADDR_W'(4);
          exp_cnt_d  = exp_cnt_q - 10'd4;
        end else begin
          // Burst start; a first beat mid-burst restarts tracking here.
          err_new[0] = (state_q == ST_BURST);
          err_new[1] = (cbus.cbus_address[1:0] != 2'b00);
          err_new[2] = (cbus.cbus_bytecnt == 10'd0);
          exp_addr_d = cbus.cbus_address + ADDR_W'(4);
          exp_cnt_d  = cbus.cbus_bytecnt - 10'd4;
        end
        err_new[3] = (be_in != be_exp);
        err_new[4] = (cbus.cbus_last != last_ok);
        state_d    = cbus.cbus_last ? ST_IDLE : ST_BURST;
      end
    end
    err_code_d = (err_clr ? 5'b00000 : err_code_q) | err_new;
  end

  always_comb begin
    wptr_d       = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d       = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d      = count_q;
    burst_done_d = pop & last_mem_q[rptr_q];
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge cbus_clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      exp_addr_q   <= '0;
      exp_cnt_q    <= '0;
      err_code_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      exp_addr_q   <= exp_addr_d;
      exp_cnt_q    <= exp_cnt_d;
      err_code_q   <= err_code_d;
      burst_done_q <= burst_done_d;
    end
  end

  always_ff @(posedge cbus_clk) begin
    if (push) begin
      addr_mem_q[wptr_q] <= {cbus.cbus_address[ADDR_W-1:2], 2'b00};
      be_mem_q[wptr_q]   <= be_in;
      data_mem_q[wptr_q] <= cbus.cbus_wdata;
      last_mem_q[wptr_q] <= cbus.cbus_last;
    end
  end

endmodule

// File: tb/tb_generic_cbus_slave_wr_ctl.sv
module tb_generic_cbus_slave_wr_ctl;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [9:0]  cnt;
    logic [3:0]  byten;
    logic        first;
    logic        last;
    logic        bem;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        last;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        big_endian_q;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        burst_done;
  logic        err;
  logic [4:0]  err_code;
  logic        err_clr;

  generic_cbus_slave_wr_ctl_if #(.ADDR_W(32)) cbus_if ();

  generic_cbus_slave_wr_ctl #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .cbus_clk     (clk),
    .rst          (rst),
    .big_endian_q (big_endian_q),
    .cbus         (cbus_if.slave),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .burst_done   (burst_done),
    .err          (err),
    .err_code     (err_code),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Stimulus, reference model and observation state
  beat_t       stim_q[$];
  wr_t         mq[$];
  logic [31:0] wr_log[$];
  logic [3:0]  be_log[$];
  logic        m_in_burst;
  logic [31:0] m_exp_addr;
  logic [9:0]  m_exp_cnt;
  logic [4:0]  m_err;
  logic        m_bd;
  int unsigned req_pct  = 100;
  int unsigned gnt_pct  = 100;
  int unsigned clr_pct  = 0;
  logic        clr_once = 1'b0;
  int unsigned n_acc    = 0;
  int unsigned dut_wr   = 0;
  int unsigned dut_bd   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] lanes(input logic [9:0] n);
    logic [4:0] m;
    if (n >= 10'd4) return 4'hF;
    m = (5'd1 << n[2:0]) - 5'd1;
    return m[3:0];
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    stim_q.delete();
    m_in_burst = 1'b0;
    m_exp_addr = '0;
    m_exp_cnt  = '0;
    m_err      = '0;
    m_bd       = 1'b0;
  endtask

  // Applies the burst rules to one accepted beat; returns new error bits.
  function automatic logic [4:0] model_beat(input beat_t b);
    logic [4:0] nb = '0;
    logic [3:0] be = b.bem ? rev4(b.byten) : b.byten;
    wr_t w;
    if (!m_in_burst && !b.first) return 5'b00001;
    if (m_in_burst && !b.first) begin
      if (b.addr[1:0] != 2'b00 || b.addr != m_exp_addr) nb[1] = 1'b1;
      if (b.cnt != m_exp_cnt || b.cnt == 0) nb[2] = 1'b1;
      m_exp_addr = m_exp_addr + 32'd4;
      m_exp_cnt  = m_exp_cnt - 10'd4;
    end else begin
      if (m_in_burst) nb[0] = 1'b1;
      if (b.addr[1:0] != 2'b00) nb[1] = 1'b1;
      if (b.cnt == 0) nb[2] = 1'b1;
      m_exp_addr = b.addr + 32'd4;
      m_exp_cnt  = b.cnt - 10'd4;
    end
    if (be != lanes(b.cnt)) nb[3] = 1'b1;
    if (b.last != (b.cnt >= 1 && b.cnt <= 4)) nb[4] = 1'b1;
    m_in_burst = !b.last;
    w.addr = {b.addr[31:2], 2'b00};
    w.be   = be;
    w.data = b.data;
    w.last = b.last;
    mq.push_back(w);
    return nb;
  endfunction

  task automatic step();
    beat_t b;
    logic acc, pop, clr;
    logic [4:0] nb = '0;
    @(negedge clk);
    acc = 1'b0;
    if (stim_q.size() != 0 && $urandom_range(99) < req_pct) begin
      b = stim_q[0];
      cbus_if.cbus_req     = 1'b1;
      cbus_if.cbus_address = b.addr;
      cbus_if.cbus_bytecnt = b.cnt;
      cbus_if.cbus_byten   = b.byten;
      cbus_if.cbus_first   = b.first;
      cbus_if.cbus_last    = b.last;
      cbus_if.cbus_wdata   = b.data;
      big_endian_q         = b.bem;
      acc = (mq.size() < DEPTH);
    end else begin
      cbus_if.cbus_req     = 1'b0;
      cbus_if.cbus_address = $urandom;
      cbus_if.cbus_bytecnt = 10'($urandom);
      cbus_if.cbus_byten   = 4'($urandom);
      cbus_if.cbus_first   = 1'($urandom);
      cbus_if.cbus_last    = 1'($urandom);
      cbus_if.cbus_wdata   = $urandom;
    end
    mem_gnt = ($urandom_range(99) < gnt_pct);
    clr = clr_once || (clr_pct != 0 && $urandom_range(99) < clr_pct);
    clr_once = 1'b0;
    err_clr = clr;
    #1;
    check("mem_wr", mem_wr, mq.size() != 0);
    check("wready", cbus_if.cbus_wready, mq.size() < DEPTH);
    check("burst_done", burst_done, m_bd);
    check("err_code", err_code, m_err);
    check("err", err, |m_err);
    if (mq.size() != 0) begin
      check("mem_addr", mem_addr, mq[0].addr);
      check("mem_be", mem_be, mq[0].be);
      check("mem_wdata", mem_wdata, mq[0].data);
    end
    if (mem_wr && mem_gnt) begin
      wr_log.push_back(mem_addr);
      be_log.push_back(mem_be);
      dut_wr++;
    end
    if (burst_done) dut_bd++;
    pop  = (mq.size() != 0) && mem_gnt;
    m_bd = pop && mq[0].last;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      void'(stim_q.pop_front());
      n_acc++;
      nb = model_beat(b);
    end
    m_err = (clr ? 5'b00000 : m_err) | nb;
  endtask

  task automatic run(input int unsigned budget);
    int unsigned n = 0;
    while ((stim_q.size() != 0 || mq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_left", stim_q.size() + mq.size(), 0);
    step();
    step();
  endtask

  task automatic add_beat(input logic [31:0] a, input logic [9:0] c, input logic [3:0] be,
                          input logic f, input logic l, input logic bem);
    beat_t b;
    b.addr = a; b.cnt = c; b.byten = be; b.first = f; b.last = l; b.bem = bem;
    b.data = $urandom;
    stim_q.push_back(b);
  endtask

  task automatic add_burst(input logic [31:0] base, input int unsigned nbytes, input logic bem);
    int unsigned beats = (nbytes + 3) / 4;
    for (int unsigned i = 0; i < beats; i++) begin
      logic [9:0] c = 10'(nbytes - 4 * i);
      add_beat(base + 32'(4 * i), c, bem ? rev4(lanes(c)) : lanes(c),
               i == 0, i == beats - 1, bem);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mem_wr", mem_wr, 0);
    check("rst_wready", cbus_if.cbus_wready, 1);
    check("rst_err", err, 0);
    model_reset();
    @(negedge clk);
    cbus_if.cbus_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned w0, b0, a0, start;
    rst = 1'b1;
    big_endian_q = 1'b0;
    mem_gnt = 1'b0;
    err_clr = 1'b0;
    cbus_if.cbus_req = 1'b0;
    cbus_if.cbus_address = '0;
    cbus_if.cbus_bytecnt = '0;
    cbus_if.cbus_byten = '0;
    cbus_if.cbus_first = 1'b0;
    cbus_if.cbus_last = 1'b0;
    cbus_if.cbus_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_mem_wr", mem_wr, 0);
    check("reset_wready", cbus_if.cbus_wready, 1);
    check("reset_err_code", err_code, 0);
    check("reset_burst_done", burst_done, 0);
    rst = 1'b0;

    // 12-byte little-endian burst
    w0 = dut_wr; b0 = dut_bd; wr_log.delete(); be_log.delete();
    add_burst(32'h100, 12, 1'b0);
    run(100);
    check("t1_writes", dut_wr - w0, 3);
    check("t1_bursts", dut_bd - b0, 1);
    check("t1_addr0", wr_log[0], 32'h100);
    check("t1_addr1", wr_log[1], 32'h104);
    check("t1_addr2", wr_log[2], 32'h108);
    check("t1_be2", be_log[2], 4'hF);
    check("t1_err", err, 0);

    // 6-byte big-endian burst
    wr_log.delete(); be_log.delete();
    add_burst(32'h200, 6, 1'b1);
    run(100);
    check("t2_be0", be_log[0], 4'b1111);
    check("t2_be1", be_log[1], 4'b0011);
    check("t2_err_code", err_code, 0);

    // Backpressure: 8 beats, no grant for 10 cycles
    wr_log.delete(); a0 = n_acc;
    add_burst(32'h500, 16, 1'b0);
    add_burst(32'h600, 16, 1'b0);
    gnt_pct = 0;
    repeat (10) step();
    check("t3_accepts", n_acc - a0, DEPTH);
    check("t3_wready", cbus_if.cbus_wready, 0);
    check("t3_head", mem_addr, 32'h500);
    gnt_pct = 100;
    run(100);
    for (int i = 0; i < 8; i++)
      check("t3_order", wr_log[i], (i < 4 ? 32'h500 : 32'h5F0) + 32'(4 * i));

    // Wrong second-beat address
    w0 = dut_wr;
    add_beat(32'h280, 8, 4'hF, 1'b1, 1'b0, 1'b0);
    add_beat(32'h288, 4, 4'hF, 1'b0, 1'b1, 1'b0);
    run(100);
    check("t4_err_code", err_code, 5'b00010);
    check("t4_writes", dut_wr - w0, 2);
    clr_once = 1'b1;
    step();
    step();
    check("t4_err_clr", err, 0);

    // Ordering errors
    w0 = dut_wr;
    add_beat(32'h2C0, 4, 4'hF, 1'b0, 1'b1, 1'b0);
    run(100);
    check("t5_order", err_code, 5'b00001);
    check("t5_no_write", dut_wr - w0, 0);
    clr_once = 1'b1;
    step();
    add_beat(32'h300, 12, 4'hF, 1'b1, 1'b0, 1'b0);
    add_beat(32'h304, 8, 4'hF, 1'b0, 1'b0, 1'b0);
    add_beat(32'h400, 8, 4'hF, 1'b1, 1'b0, 1'b0);
    add_beat(32'h404, 4, 4'hF, 1'b0, 1'b1, 1'b0);
    run(100);
    check("t5_restart", err_code, 5'b00001);
    clr_once = 1'b1;
    step();

    // Reset with beats queued
    gnt_pct = 0;
    add_burst(32'h700, 12, 1'b0);
    repeat (6) step();
    check("t6_queued", mem_wr, 1);
    do_reset();
    gnt_pct = 100;
    wr_log.delete();
    add_burst(32'h800, 8, 1'b0);
    run(100);
    check("t6_clean_err", err_code, 0);
    check("t6_clean_addr", wr_log[1], 32'h804);

    // Randomised bursts with occasional corruption
    req_pct = 75; gnt_pct = 60; clr_pct = 5;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] base = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(16'hFFFF), 2'b00};
      int unsigned nbytes = $urandom_range(20, 1);
      start = stim_q.size();
      add_burst(base, nbytes, 1'($urandom));
      if ($urandom_range(3) == 0) begin
        int unsigned j = start + $urandom_range(stim_q.size() - start - 1);
        case ($urandom_range(6))
          0: stim_q[j].addr = stim_q[j].addr + 32'd4;
          1: stim_q[j].addr[0] = 1'b1;
          2: stim_q[j].cnt = stim_q[j].cnt + 10'd4;
          3: stim_q[j].byten = stim_q[j].byten ^ 4'($urandom_range(15, 1));
          4: stim_q[j].last = ~stim_q[j].last;
          5: stim_q[j].first = ~stim_q[j].first;
          default: stim_q[j].cnt = 10'd0;
        endcase
      end
    end
    run(20000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
